div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
//  Consumes div_start from the hazard unit and returns div_ready to it.
//  The hazard unit stalls F/D/E while start=1 and ready=0.
//  Produces {HI=remainder, LO=quotient} for the hilo write path in MEM/WB.
// PARAMETERS
//  WIDTH   32   operand width; result is 2*WIDTH
//  CNT_W   6    iteration counter width; must hold WIDTH
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous, active-high reset
//  start       in   1        div_start from hazard unit; level, held through busy
//  signed_div  in   1        1=DIV (signed), 0=DIVU; sampled with start in IDLE
//  annul       in   1        cancel in-flight divide (exception flush)
//  opdata1     in   WIDTH    dividend (rs); sampled with start in IDLE
//  opdata2     in   WIDTH    divisor (rt); sampled with start in IDLE
//  ready       out  1        1-cycle pulse, 1=`DivResultReady, 0=`DivResultNotReady
//  result      out  2*WIDTH  {remainder, quotient}; valid while ready=1
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ready=0, result=0, counter=0,
//    operand and partial-remainder registers cleared.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE:
//   - start=1 & annul=0 & opdata2!=0: latch |a|,|b| (abs only if signed_div),
//     latch sign flags, counter=0, go to BUSY.
//   - start=1 & opdata2==0: go to DONE next cycle.
//     result = {opdata1, {WIDTH{1'b1}}}, i.e. rem=dividend, quo=all-ones.
//  BUSY: one quotient bit per cycle, MSB first.
//   - Shift {rem,quo} left; trial-subtract |b| from the upper WIDTH+1 bits.
//   - If non-negative, keep the difference and set quo LSB=1.
//   - counter increments each cycle; after WIDTH cycles go to DONE.
//   - start and operand inputs are ignored while BUSY.
//  DONE: ready=1 for exactly one cycle; then IDLE unconditionally.
//   - A start seen in DONE is ignored; the hazard unit drives it low here.
//  Sign fix-up, applied when entering DONE from BUSY:
//   - Negate quotient if signed_div and the operand signs differ.
//   - Negate remainder if signed_div and the dividend is negative.
//   - 0x80000000 / 0xFFFFFFFF signed gives quo=0x80000000, rem=0 (wraps).
//  Latency: start accepted at cycle T -> BUSY T+1..T+WIDTH.
//   - ready=1 at T+WIDTH+1 (T+33); divide-by-zero gives ready=1 at T+1.
//  result is registered and updates only on entry to DONE.
//   - It holds until the next DONE, so MEM/WB reads it stably after the stall.
//  ready deasserts after one cycle; a following div in EX restarts in IDLE.
//  annul=1 in BUSY or DONE: go to IDLE next cycle.
//   - ready is forced 0 that cycle; result is not updated.
//   - annul=1 in IDLE blocks acceptance.
//  Width rules: the partial remainder is WIDTH+1 bits so the subtract
//   borrow is visible; abs() of the most-negative value stays unsigned-correct.
// TESTING
//  1 DIVU 100/7, start held high -> ready=1 only at T+33;
//    result={32'd2, 32'd14}; ready=0 at T+34.
//  2 DIV -7/2 -> quo=0xFFFFFFFD, rem=0xFFFFFFFF.
//    DIV 7/-2 -> quo=0xFFFFFFFD, rem=1.
//  3 DIV 0x80000000/0xFFFFFFFF -> quo=0x80000000, rem=0.
//    DIVU same operands -> quo=0, rem=0x80000000.
//  4 Divide by zero, DIVU 5/0 -> ready=1 at T+1; result={32'd5, 32'hFFFFFFFF}.
//  5 Assert rst at BUSY iteration 10 -> ready=0, result=0 immediately.
//    Later DIVU 9/3 -> rem=0, quo=3 at T+33.
//  6 Back-to-back divides:
//    - DIVU 20/3; start low only in the DONE cycle, high again next cycle.
//      Gives {2,6}, then 15/4 gives {3,3}.
//      Second ready is exactly 34 cycles after the first.
//    - annul at BUSY iteration 5 -> no ready pulse; result keeps its prior value.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Produces {remainder, quotient}. Handshakes with the hazard unit via
// start (level, held through busy) and a one-cycle ready pulse.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + ONE;
  endfunction

  // Magnitude of an operand; only treated as signed when en is set.
  // The most-negative value maps to itself, which is correct read unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             en);
    logic [WIDTH-1:0] m;
    if (en && v[WIDTH-1]) begin
      m = negate(v);
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]       shift_rem;
  logic [WIDTH:0]       trial_diff;
  logic                 trial_fits;
  logic [WIDTH:0]       rem_step;
  logic [WIDTH-1:0]     quo_step;
  logic [WIDTH-1:0]     quo_fixed;
  logic [WIDTH-1:0]     rem_fixed;

  // One restoring iteration: shift in the next dividend bit, trial-subtract.
  always_comb begin
    shift_rem  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial_diff = shift_rem - {1'b0, dvsr_q};
    trial_fits = ~trial_diff[WIDTH];
    if (trial_fits) begin
      rem_step = trial_diff;
    end else begin
      rem_step = shift_rem;
    end
    quo_step = {quo_q[WIDTH-2:0], trial_fits};
  end

  // Sign correction of the final iteration's quotient and remainder.
  always_comb begin
    if (neg_quo_q) begin
      quo_fixed = negate(quo_step);
    end else begin
      quo_fixed = quo_step;
    end
    if (neg_rem_q) begin
      rem_fixed = negate(rem_step[WIDTH-1:0]);
    end else begin
      rem_fixed = rem_step[WIDTH-1:0];
    end
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          if (opdata2 == ZERO_W) begin
            // Divide by zero: no iterations, fixed result pattern.
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {opdata1, ALL_ONES};
          end else begin
            state_d   = BUSY;
            cnt_d     = {CNT_W{1'b0}};
            dvsr_d    = magnitude(opdata2, signed_div);
            quo_d     = magnitude(opdata1, signed_div);
            rem_d     = {(WIDTH+1){1'b0}};
            neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem_d = signed_div & opdata1[WIDTH-1];
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (annul) begin
          // Flush: drop the in-flight divide, keep the previous result.
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {rem_fixed, quo_fixed};
          end else begin
            state_d = BUSY;
          end
        end
      end
      DONE: begin
        // ready is a single-cycle pulse; a start seen here is ignored.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      dvsr_q    <= {WIDTH{1'b0}};
      rem_q     <= {(WIDTH+1){1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvsr_q    <= dvsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an
// arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        ready;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .ready      (ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic (truncating division), {rem, quo}.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Runs one divide with start held until ready; called just after a negedge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input string tag, output int ready_cyc);
    logic [63:0] exp;
    int          k;
    int          lat_exp;
    bit          found;
    exp       = model(a, b, sgn);
    lat_exp   = (b == 32'd0) ? 1 : 33;
    opdata1   = a;
    opdata2   = b;
    signed_div = sgn;
    start     = 1'b1;
    k         = 0;
    found     = 1'b0;
    ready_cyc = -1;
    while (!found && k < 40) begin
      @(negedge clk);
      k++;
      if (ready === 1'b1) begin
        found     = 1'b1;
        ready_cyc = cyc;
      end else if (k == 1) begin
        // Operands change while busy; the divider must ignore them.
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~sgn;
      end
    end
    start = 1'b0;
    check64({tag, "_latency"}, 64'(found ? k : 0), 64'(lat_exp));
    check64({tag, "_result"}, result, exp);
    @(negedge clk);
    check64({tag, "_ready_drop"}, {63'd0, ready}, 64'd0);
    check64({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int          rc1, rc2, rc;
    int          seen;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] prior;

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    repeat (2) @(negedge clk);
    check64("reset_ready", {63'd0, ready}, 64'd0);
    check64("reset_result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check64("idle_ready", {63'd0, ready}, 64'd0);

    // Directed divides, including signed corner cases and divide by zero.
    do_div(32'd100, 32'd7, 1'b0, "divu_100_7", rc);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2", rc);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2", rc);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_min_m1", rc);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_min_m1", rc);
    do_div(32'd5, 32'd0, 1'b0, "divu_5_0", rc);
    do_div(32'h8000_0000, 32'd0, 1'b1, "div_min_0", rc);

    // Asynchronous reset in the middle of an iteration sequence.
    opdata1 = 32'd50; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check64("midreset_ready", {63'd0, ready}, 64'd0);
    check64("midreset_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_div(32'd9, 32'd3, 1'b0, "divu_9_3", rc);

    // Back-to-back: start low only during the DONE cycle.
    do_div(32'd20, 32'd3, 1'b0, "b2b_20_3", rc1);
    do_div(32'd15, 32'd4, 1'b0, "b2b_15_4", rc2);
    check64("b2b_spacing", 64'(rc2 - rc1), 64'd34);

    // Annul during BUSY: no ready pulse, previous result kept.
    prior = model(32'd15, 32'd4, 1'b0);
    opdata1 = 32'd20; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready === 1'b1) seen++;
    end
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready === 1'b1) seen++;
    end
    check64("annul_busy_no_ready", 64'(seen), 64'd0);
    check64("annul_busy_result", result, prior);

    // Annul in IDLE blocks acceptance, including the divide-by-zero path.
    opdata1 = 32'd8; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready === 1'b1) seen++;
    end
    start = 1'b0; annul = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ready === 1'b1) seen++;
    end
    check64("annul_idle_no_ready", 64'(seen), 64'd0);
    check64("annul_idle_result", result, prior);

    // Randomized divides with a bias toward boundary divisors/dividends.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, $sformatf("rand%0d", i), rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
